// File: rtl/golomb_regular_mode_decoder.sv
// ---------------------------------------------------------------------------
// golomb_regular_mode_decoder
//
// Bit-serial Golomb-Rice decoder for JPEG-LS regular mode. A codeword is
// consumed one bit per accepted beat (bit_valid & bit_ready) and the mapped
// error value MErrval is rebuilt for the context parameter k latched at start.
// Two codeword forms are recognised:
//   - under-limit : q zeros, '1', k remainder bits (MSB first)
//                   -> MErrval = (q << k) | remainder
//   - limited     : QMAX zeros, '1', qbpp bits holding MErrval-1
//                   -> MErrval = bits + 1, escape = 1
// A prefix of more than QMAX zeros is malformed: error pulses, no result.
//
// Ports
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   start          begin a codeword (only looked at while idle)
//   k              Golomb parameter, captured when start is accepted
//   bit_in         next codeword bit in stream order
//   bit_valid      bit_in carries a bit
//   bit_ready      decoder takes a bit this cycle
//   merrval        decoded value
//   merrval_valid  merrval / escape / bits_consumed are valid
//   merrval_ready  downstream takes the result
//   escape         codeword was the limited form
//   bits_consumed  codeword length in bits (saturating)
//   error          one-cycle pulse after a malformed unary prefix
//   busy           decoder is not idle
// ---------------------------------------------------------------------------
module golomb_regular_mode_decoder #(
  parameter int k_length                  = 4,
  parameter int mapped_error_value_length = 9,
  parameter int encodedlength_width       = 6,
  parameter int LIMIT                     = 32,
  parameter int qbpp                      = 8
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 start,
  input  logic [k_length-1:0]                  k,
  input  logic                                 bit_in,
  input  logic                                 bit_valid,
  output logic                                 bit_ready,
  output logic [mapped_error_value_length-1:0] merrval,
  output logic                                 merrval_valid,
  input  logic                                 merrval_ready,
  output logic                                 escape,
  output logic [encodedlength_width-1:0]       bits_consumed,
  output logic                                 error,
  output logic                                 busy
);

  localparam int QMAX = LIMIT - qbpp - 1;
  localparam int KMAX = (1 << k_length) - 1;
  localparam int RW   = (KMAX > qbpp) ? KMAX : qbpp;
  localparam int QW   = $clog2(QMAX + 1);
  localparam int CW   = $clog2(RW + 1);
  localparam int MW   = mapped_error_value_length;
  localparam int LW   = encodedlength_width;
  // Wide enough to hold q shifted by the largest k without losing bits
  // before the final truncation to MW.
  localparam int WW   = QW + KMAX + RW;

  localparam logic [LW-1:0] LEN_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UNARY,
    ST_REM,
    ST_OUT
  } state_t;

  state_t          state_q,   state_d;
  logic [k_length-1:0] k_q,   k_d;
  logic [QW-1:0]   q_q,       q_d;
  logic [RW-1:0]   r_q,       r_d;
  logic [CW-1:0]   rem_cnt_q, rem_cnt_d;
  logic            esc_q,     esc_d;
  logic [LW-1:0]   len_q,     len_d;
  logic [MW-1:0]   merrval_q, merrval_d;
  logic            error_q,   error_d;

  logic            beat;
  logic [LW-1:0]   len_inc;
  logic [RW-1:0]   r_shift;

  assign bit_ready     = (state_q == ST_UNARY) || (state_q == ST_REM);
  assign merrval_valid = (state_q == ST_OUT);
  assign busy          = (state_q != ST_IDLE);
  assign merrval       = merrval_q;
  assign escape        = esc_q;
  assign bits_consumed = len_q;
  assign error         = error_q;

  assign beat    = bit_valid & bit_ready;
  assign len_inc = (len_q == LEN_MAX) ? len_q : len_q + LW'(1);
  // Remainder register with the incoming bit appended; the oldest bit falls
  // off the top, which never matters because at most RW bits are collected.
  assign r_shift = RW'({r_q, bit_in});

  // Next-state logic for the whole decoder. Registers hold unless a start
  // is accepted in IDLE or a beat lands in UNARY/REM; error defaults low so
  // it only ever lasts one cycle.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    q_d       = q_q;
    r_d       = r_q;
    rem_cnt_d = rem_cnt_q;
    esc_d     = esc_q;
    len_d     = len_q;
    merrval_d = merrval_q;
    error_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          k_d       = k;
          q_d       = '0;
          r_d       = '0;
          rem_cnt_d = '0;
          esc_d     = 1'b0;
          len_d     = '0;
          state_d   = ST_UNARY;
        end
      end

      ST_UNARY: begin
        if (beat) begin
          len_d = len_inc;
          if (!bit_in) begin
            if (q_q == QW'(QMAX)) begin
              // One zero too many: drop the codeword without a result.
              error_d = 1'b1;
              state_d = ST_IDLE;
            end else begin
              q_d = q_q + QW'(1);
            end
          end else if (q_q == QW'(QMAX)) begin
            esc_d     = 1'b1;
            rem_cnt_d = CW'(qbpp);
            state_d   = ST_REM;
          end else if (k_q == '0) begin
            merrval_d = MW'(q_q);
            state_d   = ST_OUT;
          end else begin
            rem_cnt_d = CW'(k_q);
            state_d   = ST_REM;
          end
        end
      end

      ST_REM: begin
        if (beat) begin
          r_d       = r_shift;
          rem_cnt_d = rem_cnt_q - CW'(1);
          len_d     = len_inc;
          if (rem_cnt_q == CW'(1)) begin
            state_d = ST_OUT;
            if (esc_q) begin
              merrval_d = MW'(r_shift) + MW'(1);
            end else begin
              merrval_d = MW'((WW'(q_q) << k_q) | WW'(r_shift));
            end
          end
        end
      end

      ST_OUT: begin
        if (merrval_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial codeword and
  // clears every visible output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      q_q       <= '0;
      r_q       <= '0;
      rem_cnt_q <= '0;
      esc_q     <= 1'b0;
      len_q     <= '0;
      merrval_q <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      q_q       <= q_d;
      r_q       <= r_d;
      rem_cnt_q <= rem_cnt_d;
      esc_q     <= esc_d;
      len_q     <= len_d;
      merrval_q <= merrval_d;
      error_q   <= error_d;
    end
  end

endmodule

// File: tb/tb_golomb_regular_mode_decoder.sv
// ---------------------------------------------------------------------------
// tb_golomb_regular_mode_decoder
//
// Self-checking bench for golomb_regular_mode_decoder. Directed codewords
// come from hand-written bit patterns; random codewords come from a small
// JPEG-LS Golomb encoder model, so the expected MErrval is simply the value
// that was encoded.
// ---------------------------------------------------------------------------
module tb_golomb_regular_mode_decoder;

  localparam int K_LEN = 4;
  localparam int MEV_W = 9;
  localparam int LEN_W = 6;
  localparam int LIMIT = 32;
  localparam int QBPP  = 8;
  localparam int QMAX  = LIMIT - QBPP - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [K_LEN-1:0] k;
  logic             bit_in;
  logic             bit_valid;
  logic             bit_ready;
  logic [MEV_W-1:0] merrval;
  logic             merrval_valid;
  logic             merrval_ready;
  logic             escape;
  logic [LEN_W-1:0] bits_consumed;
  logic             error;
  logic             busy;

  int checkCount = 0;
  int passCount  = 0;

  // Codeword bits in stream order for the next applyStimulus call.
  bit stream[$];

  golomb_regular_mode_decoder #(
    .k_length                  (K_LEN),
    .mapped_error_value_length (MEV_W),
    .encodedlength_width       (LEN_W),
    .LIMIT                     (LIMIT),
    .qbpp                      (QBPP)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .k             (k),
    .bit_in        (bit_in),
    .bit_valid     (bit_valid),
    .bit_ready     (bit_ready),
    .merrval       (merrval),
    .merrval_valid (merrval_valid),
    .merrval_ready (merrval_ready),
    .escape        (escape),
    .bits_consumed (bits_consumed),
    .error         (error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load the stream from the top n bits of a pattern, MSB first.
  task automatic loadBits(input logic [31:0] pattern, input int n);
    stream.delete();
    for (int i = n - 1; i >= 0; i--) stream.push_back(pattern[i]);
  endtask

  // Reference encoder: JPEG-LS limited-length Golomb code of value v.
  task automatic encodeValue(input int v, input int kk, output bit isEsc);
    int q;
    stream.delete();
    q = v >> kk;
    if (q < QMAX) begin
      isEsc = 1'b0;
      repeat (q) stream.push_back(1'b0);
      stream.push_back(1'b1);
      for (int i = kk - 1; i >= 0; i--) stream.push_back(bit'((v >> i) & 1));
    end else begin
      isEsc = 1'b1;
      repeat (QMAX) stream.push_back(1'b0);
      stream.push_back(1'b1);
      for (int i = QBPP - 1; i >= 0; i--) stream.push_back(bit'(((v - 1) >> i) & 1));
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_merrval"},       32'(merrval),       0);
    checkOutput({tag, "_valid"},         32'(merrval_valid), 0);
    checkOutput({tag, "_escape"},        32'(escape),        0);
    checkOutput({tag, "_bits_consumed"}, 32'(bits_consumed), 0);
    checkOutput({tag, "_error"},         32'(error),         0);
    checkOutput({tag, "_busy"},          32'(busy),          0);
    checkOutput({tag, "_bit_ready"},     32'(bit_ready),     0);
  endtask

  // Decode the queued stream with parameter kk and check the result, with
  // optional bit_valid gaps and a downstream stall of stallCycles.
  task automatic applyStimulus(input int kk, input int expMerr, input bit expEsc,
                               input int expLen, input bit useGaps, input int stallCycles);
    int gaps;
    // A bit offered together with start must not be consumed.
    start     = 1'b1;
    k         = K_LEN'(kk);
    bit_valid = 1'b1;
    bit_in    = 1'($urandom);
    tick();
    start     = 1'b0;
    bit_valid = 1'b0;
    k         = K_LEN'($urandom);
    checkOutput("first_ready", 32'(bit_ready), 1);
    foreach (stream[i]) begin
      if (useGaps) begin
        gaps = $urandom_range(0, 2);
        repeat (gaps) begin
          bit_valid = 1'b0;
          bit_in    = 1'($urandom);
          tick();
          checkOutput("gap_ready", 32'(bit_ready), 1);
        end
      end
      checkOutput("pre_valid", 32'(merrval_valid), 0);
      bit_valid = 1'b1;
      bit_in    = stream[i];
      tick();
    end
    bit_valid = 1'b0;
    checkOutput("valid",         32'(merrval_valid), 1);
    checkOutput("merrval",       32'(merrval),       32'(expMerr));
    checkOutput("escape",        32'(escape),        32'(expEsc));
    checkOutput("bits_consumed", 32'(bits_consumed), 32'(expLen));
    checkOutput("out_ready",     32'(bit_ready),     0);
    repeat (stallCycles) begin
      start         = 1'b1;
      bit_valid     = 1'b1;
      merrval_ready = 1'b0;
      tick();
      checkOutput("stall_valid",   32'(merrval_valid), 1);
      checkOutput("stall_merrval", 32'(merrval),       32'(expMerr));
      checkOutput("stall_len",     32'(bits_consumed), 32'(expLen));
      checkOutput("stall_ready",   32'(bit_ready),     0);
    end
    start         = 1'b0;
    bit_valid     = 1'b0;
    merrval_ready = 1'b1;
    tick();
    merrval_ready = 1'b0;
    checkOutput("done_valid", 32'(merrval_valid), 0);
    checkOutput("done_busy",  32'(busy),          0);
  endtask

  // Feed QMAX+1 zeros: the last one must raise a single error pulse.
  task automatic applyMalformed();
    start = 1'b1;
    k     = K_LEN'($urandom);
    tick();
    start = 1'b0;
    for (int i = 0; i <= QMAX; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'b0;
      tick();
      if (i < QMAX) checkOutput("err_early", 32'(error), 0);
    end
    bit_valid = 1'b0;
    checkOutput("err_pulse", 32'(error),         1);
    checkOutput("err_busy",  32'(busy),          0);
    checkOutput("err_valid", 32'(merrval_valid), 0);
    tick();
    checkOutput("err_clear", 32'(error),         0);
    checkOutput("err_valid2", 32'(merrval_valid), 0);
  endtask

  initial begin
    int  v;
    int  kk;
    bit  esc;

    reset_n       = 1'b0;
    start         = 1'b0;
    k             = '0;
    bit_in        = 1'b0;
    bit_valid     = 1'b0;
    merrval_ready = 1'b0;
    #13;
    checkAllZero("reset");
    @(posedge clk);
    #3 reset_n = 1'b1;
    tick();

    // k=2, 0,0,1,1,0 -> 10
    loadBits(32'b00110, 5);
    applyStimulus(2, 10, 1'b0, 5, 1'b0, 0);
    // k=0, 1 -> 0 ; then 0,0,0,1 -> 3
    loadBits(32'b1, 1);
    applyStimulus(0, 0, 1'b0, 1, 1'b0, 0);
    loadBits(32'b0001, 4);
    applyStimulus(0, 3, 1'b0, 4, 1'b0, 0);
    // Escape: 23 zeros, 1, 11001000 -> 201
    loadBits(32'h0000_01C8, 32);
    applyStimulus(3, 201, 1'b1, 32, 1'b0, 0);
    // Malformed prefix then a good codeword
    applyMalformed();
    loadBits(32'b00110, 5);
    applyStimulus(2, 10, 1'b0, 5, 1'b0, 0);
    // Stalls: k=4, 1,1,0,1,0 -> 10 with gaps and 3-cycle downstream stall
    loadBits(32'b11010, 5);
    applyStimulus(4, 10, 1'b0, 5, 1'b1, 3);

    // Reset in the middle of the remainder phase
    start = 1'b1;
    k     = 4'd4;
    tick();
    start = 1'b0;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    tick();
    bit_in    = 1'b1;
    tick();
    bit_valid = 1'b0;
    checkOutput("midrem_busy", 32'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    checkAllZero("midrem_reset");
    #4 reset_n = 1'b1;
    tick();
    loadBits(32'b011, 3);
    applyStimulus(1, 3, 1'b0, 3, 1'b0, 0);

    // Random codewords produced by the reference encoder
    for (int n = 0; n < 60; n++) begin
      kk = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 5);
      v  = $urandom_range(0, 511);
      if (((v >> kk) >= QMAX) && (v > 256)) v = $urandom_range(1, 256);
      encodeValue(v, kk, esc);
      applyStimulus(kk, v, esc, stream.size(), 1'($urandom), $urandom_range(0, 3));
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/golomb_regular_mode_decoder.md
# golomb_regular_mode_decoder

Bit-serial Golomb-Rice decoder for JPEG-LS regular mode, the receive-side counterpart of the regular-mode encoder.
- Consumes a codeword one bit per accepted beat and reconstructs MErrval for the context k supplied at start.
- Handles the under-limit codeword (unary zeros, '1', k remainder bits MSB-first) and the limited/escape codeword (LIMIT-qbpp-1 zeros, '1', qbpp bits of MErrval-1).
- Sits between the bitstream unpacker and the error-unmapping / reconstruction stage of the decoder datapath.

## Interface
Parameters:
- k_length, 4, width of k
- mapped_error_value_length, 9, width of MErrval
- encodedlength_width, 6, width of the codeword-length output
- LIMIT, 32, JPEG-LS LIMIT
- qbpp, 8, bits per escaped value; QMAX = LIMIT-qbpp-1 (23 by default)

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin a codeword; sampled only in IDLE
- k  in  k_length  Golomb parameter; latched on accepted start
- bit_in  in  1  next codeword bit, in stream order
- bit_valid  in  1  bit_in is valid
- bit_ready  out  1  decoder accepts a bit this cycle
- merrval  out  mapped_error_value_length  decoded value
- merrval_valid  out  1  merrval, escape, bits_consumed valid
- merrval_ready  in  1  downstream accepts the result
- escape  out  1  codeword was the limited form
- bits_consumed  out  encodedlength_width  codeword length in bits
- error  out  1  one-cycle pulse on a malformed unary prefix
- busy  out  1  state != IDLE

## Operation
- Beat: bit_valid & bit_ready at a rising edge.
- Registers: k_r, q (unary count, 0..QMAX), r (remainder shift register), rem_cnt, esc_r, len.
- IDLE:
  - bit_ready=0.
  - On start: k_r<=k; q, r, len, esc_r <= 0; go to UNARY.
- UNARY (bit_ready=1). Every beat: len++.
  - bit 0 with q<QMAX: q++.
  - bit 0 with q==QMAX: pulse error for one cycle, go to IDLE, no result.
  - bit 1 with q==QMAX: esc_r<=1, rem_cnt<=qbpp, go to REM.
  - bit 1 with q<QMAX and k_r==0: merrval<=q, go to OUT.
  - bit 1 with q<QMAX and k_r>0: rem_cnt<=k_r, go to REM.
- REM (bit_ready=1). Every beat: r<={r,bit_in}, rem_cnt--, len++.
  - When the beat consumes rem_cnt==1, go to OUT with merrval as follows.
  - Normal: merrval <= (q<<k_r)|r, truncated to mapped_error_value_length.
  - Escape: merrval <= r+1, truncated likewise.
- OUT:
  - merrval_valid=1; merrval, escape, bits_consumed held stable.
  - bit_ready=0; start ignored.
  - On merrval_ready: go to IDLE.
- Width rules:
  - r is max(2^k_length-1, qbpp) bits wide.
  - bits_consumed saturates at 2^encodedlength_width-1. This is unreachable for LIMIT ≤ 2^encodedlength_width-1; with defaults the maximum length is 32.
- Boundaries:
  - start outside IDLE: ignored.
  - k changes after latch: no effect.
  - bit_valid low: state and counters hold.
  - bit_valid and start in the same cycle in IDLE: only start acts; the bit is not consumed.
- Reset:
  - Asserted at any time, including mid-codeword, state returns to IDLE.
  - merrval, merrval_valid, escape, bits_consumed, error, busy, bit_ready all go to 0.
  - All internal registers clear; a partial codeword is discarded.

## Timing
- Decoder outputs are registered; merrval_valid asserts the cycle after the last codeword bit is accepted.
- Start to first bit_ready: 1 cycle.
- With bit_valid held high, an L-bit codeword is accepted in L consecutive cycles after start.
- Next start is possible 1 cycle after the OUT handshake, because IDLE is re-entered.
- Minimum period per codeword: L+2 cycles, plus downstream stall.
- error pulses in the cycle after the offending beat, coincident with IDLE.
- Outputs after reset: all 0.

## Test plan
- k=2, bits 0,0,1,1,0: merrval=10, escape=0, bits_consumed=5, valid 1 cycle after the 5th beat.
- k=0, bits 1: merrval=0, length 1. Then a new codeword with k=0, bits 0,0,0,1: merrval=3, length 4.
- Escape, defaults: k=3, 23 zeros, 1, then 1,1,0,0,1,0,0,0: merrval=201, escape=1, bits_consumed=32.
- Malformed prefix: 24 consecutive zeros. error pulses exactly once, merrval_valid never asserts, busy=0 next cycle, and a following codeword decodes correctly.
- Stalls: k=4, bits 1,1,0,1,0 with bit_valid gaps in REM, then merrval_ready low 3 cycles.
  - Counters do not advance during gaps.
  - Result merrval=10, bits_consumed=5, held stable throughout the stall.
  - bit_ready=0 and start is ignored while in OUT.
- Reset mid-REM: deassert reset_n asynchronously between clock edges. All outputs go to 0 immediately; after release, start with k=1 and bits 0,1,1 yields merrval=3.
